// File: rtl/mux8_pkg.sv
// Shared constants for the 8-way data selector family.
// The optional registered parity output is enabled with MUX8_PARITY_EN.
package mux8_pkg;
    localparam int SEL_W     = 3;
    localparam int N_INPUTS  = 8;
    localparam int DEF_WIDTH = 4;

    localparam logic [SEL_W-1:0] SEL_A = 3'd0;
    localparam logic [SEL_W-1:0] SEL_B = 3'd1;
    localparam logic [SEL_W-1:0] SEL_C = 3'd2;
    localparam logic [SEL_W-1:0] SEL_D = 3'd3;
    localparam logic [SEL_W-1:0] SEL_E = 3'd4;
    localparam logic [SEL_W-1:0] SEL_F = 3'd5;
    localparam logic [SEL_W-1:0] SEL_G = 3'd6;
    localparam logic [SEL_W-1:0] SEL_H = 3'd7;
endpackage

// File: rtl/mux_4_to_1.sv
// Four-input WIDTH-bit selector on a 2-bit code; building block of mux_8_to_1.
module mux_4_to_1 #(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y
);
    // The X default only matters for an unknown select in simulation;
    // every real code is listed.
    always_comb begin
        y = 'x;
        case (sel)
            2'd0: y = a;
            2'd1: y = b;
            2'd2: y = c;
            2'd3: y = d;
        endcase
    end
endmodule

// File: rtl/mux_8_to_1.sv
// Eight-input selector: combinational O plus a registered copy O_q.
// Define MUX8_PARITY_EN to add O_par, the registered XOR reduction of O_q.
module mux_8_to_1
    import mux8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] H,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] O_q
`ifdef MUX8_PARITY_EN
    ,
    output logic             O_par
`endif
);
    logic [WIDTH-1:0] lo_y;
    logic [WIDTH-1:0] hi_y;

    mux_4_to_1 #(.WIDTH(WIDTH)) u_lo (
        .sel (sel[1:0]),
        .a   (A),
        .b   (B),
        .c   (C),
        .d   (D),
        .y   (lo_y)
    );

    mux_4_to_1 #(.WIDTH(WIDTH)) u_hi (
        .sel (sel[1:0]),
        .a   (E),
        .b   (F),
        .c   (G),
        .d   (H),
        .y   (hi_y)
    );

    // The top select bit picks the A..D or E..H half.
    always_comb begin
        O = 'x;
        case (sel[SEL_W-1])
            1'b0: O = lo_y;
            1'b1: O = hi_y;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            O_q <= '0;
        end else begin
            O_q <= O;
        end
    end

`ifdef MUX8_PARITY_EN
    // Computed from O so the parity lands on the same edge as O_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            O_par <= 1'b0;
        end else begin
            O_par <= ^O;
        end
    end
`endif
endmodule

// File: tb/tb_mux_8_to_1.sv
// Self-checking bench for mux_8_to_1: directed cases plus randomized traffic
// against an array-indexed reference model. Honours MUX8_PARITY_EN.
module tb_mux_8_to_1;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [2:0]   sel;
    logic [W-1:0] din [8];
    logic [W-1:0] O;
    logic [W-1:0] O_q;
`ifdef MUX8_PARITY_EN
    logic         o_par;
`endif

    int n_cmp;
    int n_mis;
    logic [W-1:0] exp_q [$];

    mux_8_to_1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (din[0]),
        .B     (din[1]),
        .C     (din[2]),
        .D     (din[3]),
        .E     (din[4]),
        .F     (din[5]),
        .G     (din[6]),
        .H     (din[7]),
        .sel   (sel),
        .O     (O),
        .O_q   (O_q)
`ifdef MUX8_PARITY_EN
        ,
        .O_par (o_par)
`endif
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the output is simply the data element numbered by sel.
    function automatic logic [W-1:0] model_o();
        return din[sel];
    endfunction

    task automatic check_o(input string tag);
        check(tag, O, model_o());
    endtask

    // Queue the value O_q must take at the next edge, then compare after it.
    task automatic tick(input string tag);
        logic [W-1:0] e;
        e = rst ? '0 : model_o();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, O_q, e);
`ifdef MUX8_PARITY_EN
        check({tag, "_par"}, {{(W-1){1'b0}}, o_par}, {{(W-1){1'b0}}, ^e});
`endif
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 8; i++) din[i] = W'(7 - i);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst   = 1'b1;
        sel   = 3'd0;
        set_ramp();
        #1;
        check("reset_oq", O_q, '0);

        // O follows sel with reset held and no dependence on the clock.
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            check("ramp_o", O, W'(7 - s));
            #8;
            check("ramp_o_hold", O, W'(7 - s));
            check("ramp_oq_rst", O_q, '0);
            #1;
        end

        @(negedge clk);
        rst = 1'b0;
        sel = 3'd3;
        #1;
        check("sel3_o", O, 4'd4);
        tick("sel3_oq");
        check("sel3_oq_val", O_q, 4'd4);
        sel = 3'd6;
        tick("sel6_oq");
        check("sel6_oq_val", O_q, 4'd1);

        sel = 3'd2;
        din[2] = 4'd9;
        #1;
        check("c9_o", O, 4'd9);
        tick("c9_oq");
        din[2] = 4'd5;

        // Asynchronous reset between edges clears only O_q.
        sel = 3'd3;
        tick("pre_rst_oq");
        rst = 1'b1;
        #1;
        check("async_rst_oq", O_q, '0);
        check("async_rst_o", O, 4'd4);
        #2;
        rst = 1'b0;
        tick("post_rst_oq");
        check("post_rst_oq_val", O_q, 4'd4);

        for (int i = 0; i < 8; i++) din[i] = 4'hF;
        din[7] = 4'h0;
        sel = 3'd7;
        #1;
        check("edge_h0", O, 4'h0);
        sel = 3'd0;
        #1;
        check("edge_af", O, 4'hF);
        tick("edge_af_oq");

`ifdef MUX8_PARITY_EN
        set_ramp();
        sel = 3'd0;
        tick("par_a7");
        check("par_a7_val", {{(W-1){1'b0}}, o_par}, 4'd1);
        sel = 3'd2;
        tick("par_c5");
        check("par_c5_val", {{(W-1){1'b0}}, o_par}, 4'd0);
        sel = 3'd0;
        tick("par_a7b");
        rst = 1'b1;
        #1;
        check("par_rst", {{(W-1){1'b0}}, o_par}, 4'd0);
        #2;
        rst = 1'b0;
`endif

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 8; i++) din[i] = W'($urandom_range(0, (1 << W) - 1));
            sel = 3'($urandom_range(0, 7));
            #1;
            check("rand_o", O, model_o());
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                #1;
                check("rand_rst_oq", O_q, '0);
                check_o("rand_rst_o");
                #1;
                rst = 1'b0;
            end
            tick("rand_oq");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
